// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions raw board pushbutton/switch pins for the SoC core. Each channel
// is handled independently: optional polarity inversion, a two-flop
// synchroniser, a stability-counter debouncer, registered edge pulses and a
// sticky interrupt-pending flag that stays set until the core acknowledges it.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset (clears every register)
//   btn_in       raw asynchronous pin levels, one bit per channel
//   irq_ack      per-channel acknowledge, clears irq_pending (pulse or level)
//   btn_level    debounced level, active-high
//   btn_rise     one-cycle pulse on a debounced 0->1 transition
//   btn_fall     one-cycle pulse on a debounced 1->0 transition
//   irq_pending  sticky press flag, set by btn_rise, cleared by irq_ack
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
module button_conditioner #(
   parameter int NUM_BUTTONS     = 4,
   parameter int DEBOUNCE_CYCLES = 16000,
   parameter int CNT_WIDTH       = 16,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_in,
   input  logic [NUM_BUTTONS-1:0] irq_ack,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_rise,
   output logic [NUM_BUTTONS-1:0] btn_fall,
   output logic [NUM_BUTTONS-1:0] irq_pending
);

   // Terminal count: the mismatch seen on this count is the one that is
   // accepted, so a new level needs DEBOUNCE_CYCLES consecutive mismatches.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [NUM_BUTTONS-1:0]                pin_s;
   logic [NUM_BUTTONS-1:0]                sync1_r;
   logic [NUM_BUTTONS-1:0]                sync2_r;
   logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] cnt_r;
   logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] cnt_nxt_s;
   logic [NUM_BUTTONS-1:0]                level_nxt_s;
   logic [NUM_BUTTONS-1:0]                rise_nxt_s;
   logic [NUM_BUTTONS-1:0]                fall_nxt_s;
   logic [NUM_BUTTONS-1:0]                pending_nxt_s;

   // Polarity normalisation ahead of the synchroniser so everything after it
   // is active-high.
   always_comb begin
      pin_s = btn_in;
      if (ACTIVE_LOW != 0) begin
         pin_s = ~btn_in;
      end else begin
         pin_s = btn_in;
      end
   end

   // Debounce decision and sticky-flag update for every channel.
   always_comb begin
      cnt_nxt_s     = cnt_r;
      level_nxt_s   = btn_level;
      rise_nxt_s    = '0;
      fall_nxt_s    = '0;
      // A rise on the same edge as an ack wins: the press is not lost.
      pending_nxt_s = btn_rise | (irq_pending & ~irq_ack);
      for (int c = 0; c < NUM_BUTTONS; c++) begin
         if (sync2_r[c] == btn_level[c]) begin
            // Any cycle of agreement restarts the stability window.
            cnt_nxt_s[c] = '0;
         end else if (cnt_r[c] == CNT_LAST) begin
            cnt_nxt_s[c]   = '0;
            level_nxt_s[c] = sync2_r[c];
            rise_nxt_s[c]  = sync2_r[c];
            fall_nxt_s[c]  = ~sync2_r[c];
         end else begin
            cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
         end
      end
   end

   // State registers: synchroniser, counters, level, pulses and pending flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r     <= '0;
         sync2_r     <= '0;
         cnt_r       <= '0;
         btn_level   <= '0;
         btn_rise    <= '0;
         btn_fall    <= '0;
         irq_pending <= '0;
      end else begin
         sync1_r     <= pin_s;
         sync2_r     <= sync1_r;
         cnt_r       <= cnt_nxt_s;
         btn_level   <= level_nxt_s;
         btn_rise    <= rise_nxt_s;
         btn_fall    <= fall_nxt_s;
         irq_pending <= pending_nxt_s;
      end
   end

endmodule
